// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // Receiver FSM encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t IDLE  = 3'd0;
  localparam rx_state_t START = 3'd1;
  localparam rx_state_t DATA  = 3'd2;
  localparam rx_state_t STOP  = 3'd3;
  localparam rx_state_t BREAK = 3'd4;

  // Width of a down-counter that must hold values 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);

  // Head is masked so the output reads zero while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because reads are masked.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rxd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(UART_DATA_BITS);

  logic                      rx_s1, rxs;
  rx_state_t                 state, state_d;
  logic [CW-1:0]             cnt, cnt_d;
  logic [BW-1:0]             bit_idx, bit_d;
  logic [UART_DATA_BITS-1:0] shreg, sh_d;
  logic                      push, pop, fifo_full, fifo_empty;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  // Frame FSM: every sample point is where the down-counter reaches zero.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    sh_d      = shreg;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = CW'(CLKS_PER_BIT / 2 - 1);
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
            cnt_d   = CW'(CLKS_PER_BIT - 1);
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_d  = {rxs, shreg[UART_DATA_BITS-1:1]};
          cnt_d = CW'(CLKS_PER_BIT - 1);
          if (bit_idx == BW'(UART_DATA_BITS - 1)) state_d = STOP;
          else                                    bit_d   = bit_idx + 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      BREAK: begin
        // Hold here while the line stays low so a break reports only once.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= sh_d;
    end
  end

  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;
  // A good byte is lost only when there is no room and no simultaneous pop.
  assign overrun  = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] pop_q[$];
  int         pop_t[$];
  int         fe_t[$];
  int         ov_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] prev_data;
  logic       prev_hold = 1'b0;
  int         t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: logs pops and pulses, and checks the head holds while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && rx_valid) check("hold_stable", {24'h0, rx_data}, {24'h0, prev_data});
      if (rx_valid && rx_ready) begin
        pop_q.push_back(rx_data);
        pop_t.push_back(cyc);
      end
      if (frame_err) fe_t.push_back(cyc);
      if (overrun)   ov_t.push_back(cyc);
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_q.delete();
    pop_t.delete();
    fe_t.delete();
    ov_t.delete();
    exp_q.delete();
  endtask

  // Drives one 10-bit frame; rxd falls in the cycle the task is entered.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    t0  = cyc;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) tick();
    end
    rxd = stop;
    repeat (CPB) tick();
    rxd = 1'b1;
  endtask

  // Pops with a randomly toggling ready until n bytes are seen or budget runs out.
  task automatic drain(input int n);
    int k = 0;
    while (pop_q.size() < n && k < 400) begin
      rx_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    rx_ready = 1'b0;
    check("drain_count", pop_q.size(), n);
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (pop_q.size() > i) ? {24'h0, pop_q[i]} : 32'hdead;
  endfunction

  function automatic logic [31:0] rel_t(input int q[$], input int i);
    return (q.size() > i) ? 32'(q[i] - t0) : 32'hdead;
  endfunction

  initial begin
    int n;
    int t5;
    logic [7:0] b;

    // Reset state
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Single byte with exact latency
    rx_ready = 1'b1;
    clear_logs();
    send_frame(8'h55, 1'b1);
    repeat (10) tick();
    check("single_n", pop_q.size(), 1);
    check("single_data", pop_at(0), 8'h55);
    check("single_lat", rel_t(pop_t, 0), 155);
    check("single_ferr", fe_t.size(), 0);
    check("single_ovr", ov_t.size(), 0);

    // Glitches of random width shorter than half a bit
    for (int g = 0; g < 3; g++) begin
      clear_logs();
      rxd = 1'b0;
      repeat ($urandom_range(1, 7)) tick();
      rxd = 1'b1;
      repeat (30) tick();
      check("glitch_valid", rx_valid, 0);
      check("glitch_pops", pop_q.size(), 0);
      check("glitch_ferr", fe_t.size(), 0);
    end

    // Framing error followed by a held-low break
    clear_logs();
    send_frame(8'hA3, 1'b0);
    rxd = 1'b0;
    repeat (40) tick();
    rxd = 1'b1;
    repeat (20) tick();
    check("ferr_n", fe_t.size(), 1);
    check("ferr_time", rel_t(fe_t, 0), 154);
    check("ferr_pops", pop_q.size(), 0);
    clear_logs();
    send_frame(8'h3C, 1'b1);
    repeat (10) tick();
    check("after_ferr_data", pop_at(0), 8'h3C);
    check("after_ferr_ferr", fe_t.size(), 0);

    // Overrun: five back-to-back bytes into a depth-4 FIFO
    rx_ready = 1'b0;
    clear_logs();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 4) check("ovr_count4", fifo_count, 4);
    end
    repeat (10) tick();
    check("ovr_n", ov_t.size(), 1);
    check("ovr_time", rel_t(ov_t, 0), 154);
    check("ovr_count", fifo_count, 4);
    drain(4);
    for (int i = 0; i < 4; i++) check("ovr_drain", pop_at(i), 32'(i + 1));
    check("ovr_empty", fifo_count, 0);

    // Push and pop in the same cycle while full
    clear_logs();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    fork
      send_frame(8'h14, 1'b1);
      begin
        repeat (154) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (5) tick();
    check("pp_ovr", ov_t.size(), 0);
    check("pp_count", fifo_count, 4);
    check("pp_first", pop_at(0), 8'h10);
    clear_logs();
    drain(4);
    for (int i = 0; i < 4; i++) check("pp_drain", pop_at(i), 8'h11 + 32'(i));

    // Reset mid-frame with bytes queued
    clear_logs();
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    check("rmf_count", fifo_count, 2);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (CPB + 3 * CPB + 8) tick();
        rst = 1'b1;
        #1;
        check("rmf_valid", rx_valid, 0);
        check("rmf_data", rx_data, 0);
        check("rmf_count0", fifo_count, 0);
        check("rmf_ferr", frame_err, 0);
        check("rmf_ovr", overrun, 0);
      end
    join
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    clear_logs();
    rx_ready = 1'b1;
    send_frame(8'hE7, 1'b1);
    repeat (10) tick();
    check("rmf_fresh_n", pop_q.size(), 1);
    check("rmf_fresh", pop_at(0), 8'hE7);

    // Random streaming with consumer always ready: every byte arrives in order
    clear_logs();
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (10) tick();
    check("rnd_n", pop_q.size(), exp_q.size());
    for (int i = 0; i < 6; i++) check("rnd_data", pop_at(i), {24'h0, exp_q[i]});
    check("rnd_ovr", ov_t.size(), 0);

    // Random burst with stalled consumer: first DEPTH bytes kept, rest dropped
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      rx_ready = 1'b0;
      n = $urandom_range(5, 7);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
      end
      repeat (10) tick();
      check("burst_count", fifo_count, DEPTH);
      check("burst_ovr", ov_t.size(), n - DEPTH);
      t5 = pop_q.size();
      check("burst_nopop", t5, 0);
      drain(DEPTH);
      for (int i = 0; i < DEPTH; i++) check("burst_data", pop_at(i), {24'h0, exp_q[i]});
      repeat (5) tick();
      check("burst_extra", pop_q.size(), DEPTH);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
